pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of stall-cycle counter.
REQ-002 SHALL have clk_i  in  1  single clock; all state on rising edge.
REQ-003 SHALL have rst_i  in  1  synchronous, active-high reset.
REQ-004 SHALL have id_rs_i, id_rt_i  in  5 each  source registers of instruction in ID.
REQ-005 SHALL have idex_memread_i  in  1, idex_rt_i  in  5  load in EX and its destination.
REQ-006 SHALL have branch_taken_i  in  1  branch resolved taken in ID.
REQ-007 SHALL have dc_miss_i, dc_dirty_i  in  1 each  data-cache miss, victim line dirty, MEM stage.
REQ-008 SHALL have mem_req_o  out  1, mem_we_o  out  1, mem_ack_i  in  1  memory request/write-enable/one-cycle acknowledge.
REQ-009 SHALL have dc_refill_o  out  1  one-cycle pulse to write fetched line into cache.
REQ-010 SHALL have pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o, memwb_stall_o  out  1 each  hold the PC and each pipeline register.
REQ-011 SHALL have ifid_flush_o, idex_flush_o  out  1 each  bubble insertion.
REQ-012 SHALL have stall_cnt_o  out  CNT_W  count of stalled cycles.

Function
REQ-013 FSM states SHALL be IDLE, WB_REQ, ALLOC_REQ, REFILL.
REQ-014 IDLE: dc_miss_i&dc_dirty_i -> WB_REQ; dc_miss_i&~dc_dirty_i -> ALLOC_REQ; else stay.
REQ-015 WB_REQ: mem_req_o=1, mem_we_o=1; mem_ack_i -> ALLOC_REQ, else stay.
REQ-016 ALLOC_REQ: mem_req_o=1, mem_we_o=0; mem_ack_i -> REFILL, else stay.
REQ-017 REFILL: dc_refill_o=1 for exactly one cycle, then unconditionally -> IDLE.
REQ-018 mem_req_o, mem_we_o, dc_refill_o SHALL be Moore outputs decoded from state only; 0 in IDLE.
REQ-019 mem_ack_i SHALL be ignored in IDLE and REFILL.
REQ-020 mem_stall = (state!=IDLE) | dc_miss_i, combinational, same cycle.
REQ-021 mem_stall SHALL assert all five stall outputs and force both flushes to 0 (highest priority).
REQ-022 load_use = idex_memread_i & idex_rt_i!=0 & (idex_rt_i==id_rs_i | idex_rt_i==id_rt_i).
REQ-023 load_use & ~mem_stall SHALL assert pc_stall_o, ifid_stall_o, idex_flush_o only; one bubble per hazard.
REQ-024 branch_taken_i & ~mem_stall & ~load_use SHALL assert ifid_flush_o only; load-use wins over branch (branch re-resolved next cycle).
REQ-025 Stall/flush outputs SHALL be combinational, zero latency.
REQ-026 stall_cnt_o SHALL increment each cycle pc_stall_o=1, saturating at all-ones.

Reset
REQ-027 On clock edge with rst_i=1: state=IDLE, stall_cnt_o=0.
REQ-028 While rst_i=1 all stall, flush, mem_req_o, mem_we_o, dc_refill_o SHALL be 0.
REQ-029 Reset mid-transaction SHALL abandon it; mem_req_o=0 from the reset cycle; no refill pulse.

Structure
REQ-030 State encodings (2-bit) SHALL live in shared package pipe_ctrl_pkg.
REQ-031 Load-use compare SHALL be sub-module hazard_detect (combinational); FSM, priority mux, counter in top.

Verification
REQ-032 Load-use: idex_memread=1, idex_rt=5, id_rs=5 -> pc_stall=ifid_stall=idex_flush=1 one cycle; idex_rt=0 -> no stall.
REQ-033 Clean miss: dc_miss=1, dirty=0, ack on 3rd ALLOC_REQ cycle -> mem_req=1,we=0 three cycles, dc_refill one cycle, all stalls high 5 cycles, stall_cnt=5.
REQ-034 Dirty miss: dc_miss=1, dirty=1 -> WB_REQ with we=1 until ack, then ALLOC_REQ we=0, REFILL, IDLE.
REQ-035 Priority: dc_miss, load_use, branch_taken all 1 -> all stalls 1, both flushes 0; miss cleared, load_use+branch -> idex_flush=1, ifid_flush=0.
REQ-036 Reset in ALLOC_REQ -> mem_req=0 same cycle, IDLE next, no dc_refill, stall_cnt=0.
REQ-037 Saturation: CNT_W=4, 20 stalled cycles -> stall_cnt_o=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller.
//   RegAddrW   : width of a register-file address
//   dc_state_e : data-cache miss handler states (2-bit encoding)
package pipe_ctrl_pkg;

    localparam int unsigned RegAddrW = 5;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StWbReq    = 2'b01,
        StAllocReq = 2'b10,
        StRefill   = 2'b11
    } dc_state_e;

    // True while the handler is waiting on the memory interface.
    function automatic logic is_mem_state(dc_state_e s);
        return (s == StWbReq) || (s == StAllocReq);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
//   idex_memread_i : instruction in EX is a load
//   idex_rt_i      : destination register of that load
//   id_rs_i/id_rt_i: source registers of the instruction in ID
//   load_use_o     : ID consumes the load result next cycle
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                idex_memread_i,
    input  logic [RegAddrW-1:0] idex_rt_i,
    input  logic [RegAddrW-1:0] id_rs_i,
    input  logic [RegAddrW-1:0] id_rt_i,
    output logic                load_use_o
);

    // r0 is hardwired to zero, so a load into it never creates a dependency.
    assign load_use_o = idex_memread_i && (idex_rt_i != '0) &&
                        ((idex_rt_i == id_rs_i) || (idex_rt_i == id_rt_i));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller with data-cache miss handler.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   id_rs_i, id_rt_i         : ID-stage source registers
//   idex_memread_i, idex_rt_i: load in EX and its destination
//   branch_taken_i           : branch resolved taken in ID
//   dc_miss_i, dc_dirty_i    : MEM-stage cache miss, victim dirty
//   mem_req_o/mem_we_o       : memory request / write enable
//   mem_ack_i                : one-cycle memory acknowledge
//   dc_refill_o              : one-cycle pulse to write fetched line
//   *_stall_o, *_flush_o     : pipeline hold / bubble controls
//   stall_cnt_o              : saturating count of PC-stalled cycles
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [RegAddrW-1:0] id_rs_i,
    input  logic [RegAddrW-1:0] id_rt_i,
    input  logic                idex_memread_i,
    input  logic [RegAddrW-1:0] idex_rt_i,
    input  logic                branch_taken_i,
    input  logic                dc_miss_i,
    input  logic                dc_dirty_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    input  logic                mem_ack_i,
    output logic                dc_refill_o,
    output logic                pc_stall_o,
    output logic                ifid_stall_o,
    output logic                idex_stall_o,
    output logic                exmem_stall_o,
    output logic                memwb_stall_o,
    output logic                ifid_flush_o,
    output logic                idex_flush_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    dc_state_e        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             load_use;
    logic             mem_stall;

    hazard_detect u_hazard_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .load_use_o     (load_use)
    );

    // Miss handler next state; ack is only meaningful in the request states.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (dc_miss_i) begin
                    state_d = dc_dirty_i ? StWbReq : StAllocReq;
                end
            end
            StWbReq: begin
                if (mem_ack_i) begin
                    state_d = StAllocReq;
                end
            end
            StAllocReq: begin
                if (mem_ack_i) begin
                    state_d = StRefill;
                end
            end
            StRefill: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // The miss itself stalls in the cycle it is seen, before the FSM leaves idle.
    assign mem_stall = (state_q != StIdle) || dc_miss_i;

    // Priority: memory stall > load-use bubble > taken-branch flush.
    // Everything is forced low while reset is held so an abandoned
    // transaction drops its request in the reset cycle itself.
    always_comb begin
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        dc_refill_o   = 1'b0;
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        idex_stall_o  = 1'b0;
        exmem_stall_o = 1'b0;
        memwb_stall_o = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        if (!rst_i) begin
            mem_req_o   = is_mem_state(state_q);
            mem_we_o    = (state_q == StWbReq);
            dc_refill_o = (state_q == StRefill);
            if (mem_stall) begin
                pc_stall_o    = 1'b1;
                ifid_stall_o  = 1'b1;
                idex_stall_o  = 1'b1;
                exmem_stall_o = 1'b1;
                memwb_stall_o = 1'b1;
            end else if (load_use) begin
                pc_stall_o   = 1'b1;
                ifid_stall_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (branch_taken_i) begin
                ifid_flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (pc_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    typedef struct packed {
        logic       rst;
        logic       miss;
        logic       dirty;
        logic       ack;
        logic       memread;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
    } stim_t;

    // Expected output vector bit order:
    // {pc, ifid, idex, exmem, memwb stall, ifid_flush, idex_flush, req, we, refill}
    localparam logic [9:0] EIdle   = 10'b00000_00_000;
    localparam logic [9:0] EMiss   = 10'b11111_00_000;
    localparam logic [9:0] EAlloc  = 10'b11111_00_100;
    localparam logic [9:0] EWb     = 10'b11111_00_110;
    localparam logic [9:0] ERefill = 10'b11111_00_001;
    localparam logic [9:0] ELdUse  = 10'b11000_01_000;
    localparam logic [9:0] EBranch = 10'b00000_10_000;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       idex_memread, branch_taken, dc_miss, dc_dirty, mem_ack;

    logic        mem_req, mem_we, dc_refill;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
    logic        ifid_flush, idex_flush;
    logic [31:0] stall_cnt;

    logic       mem_req4, mem_we4, dc_refill4;
    logic       pc_stall4, ifid_stall4, idex_stall4, exmem_stall4, memwb_stall4;
    logic       ifid_flush4, idex_flush4;
    logic [3:0] stall_cnt4;

    logic [9:0] obs, obs4;
    assign obs  = {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                   ifid_flush, idex_flush, mem_req, mem_we, dc_refill};
    assign obs4 = {pc_stall4, ifid_stall4, idex_stall4, exmem_stall4, memwb_stall4,
                   ifid_flush4, idex_flush4, mem_req4, mem_we4, dc_refill4};

    int          checks = 0;
    int          errors = 0;
    int unsigned cnt_exp = 0;
    logic [3:0]  cnt4_exp = '0;
    stim_t       stim_q[$];
    logic [9:0]  exp_q[$];

    pipe_stall_ctrl u_dut (
        .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .idex_memread_i(idex_memread), .idex_rt_i(idex_rt), .branch_taken_i(branch_taken),
        .dc_miss_i(dc_miss), .dc_dirty_i(dc_dirty), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_ack_i(mem_ack), .dc_refill_o(dc_refill), .pc_stall_o(pc_stall),
        .ifid_stall_o(ifid_stall), .idex_stall_o(idex_stall), .exmem_stall_o(exmem_stall),
        .memwb_stall_o(memwb_stall), .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush),
        .stall_cnt_o(stall_cnt)
    );

    pipe_stall_ctrl #(.CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .idex_memread_i(idex_memread), .idex_rt_i(idex_rt), .branch_taken_i(branch_taken),
        .dc_miss_i(dc_miss), .dc_dirty_i(dc_dirty), .mem_req_o(mem_req4), .mem_we_o(mem_we4),
        .mem_ack_i(mem_ack), .dc_refill_o(dc_refill4), .pc_stall_o(pc_stall4),
        .ifid_stall_o(ifid_stall4), .idex_stall_o(idex_stall4), .exmem_stall_o(exmem_stall4),
        .memwb_stall_o(memwb_stall4), .ifid_flush_o(ifid_flush4), .idex_flush_o(idex_flush4),
        .stall_cnt_o(stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk(logic r, logic m, logic d, logic a, logic mr,
                                 logic [4:0] ert, logic [4:0] s, logic [4:0] t, logic b);
        stim_t x;
        x = '{rst: r, miss: m, dirty: d, ack: a, memread: mr, ex_rt: ert, rs: s, rt: t, br: b};
        return x;
    endfunction

    task automatic apply(input stim_t s);
        rst          = s.rst;
        dc_miss      = s.miss;
        dc_dirty     = s.dirty;
        mem_ack      = s.ack;
        idex_memread = s.memread;
        idex_rt      = s.ex_rt;
        id_rs        = s.rs;
        id_rt        = s.rt;
        branch_taken = s.br;
    endtask

    // Counter model: cleared by a reset edge, else counts expected pc_stall.
    task automatic model_cnt(input stim_t s, input logic [9:0] e);
        if (s.rst) begin
            cnt_exp  = 0;
            cnt4_exp = '0;
        end else if (e[9]) begin
            cnt_exp = cnt_exp + 1;
            if (cnt4_exp != 4'hf) cnt4_exp = cnt4_exp + 4'd1;
        end
    endtask

    task automatic push(input stim_t s, input logic [9:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        stim_t s; logic [9:0] e; int cyc = 0;
        push(mk(1, 1, 1, 1, 1, 5'd5, 5'd5, 5'd0, 1), EIdle);
        push(mk(1, 0, 0, 0, 1, 5'd3, 5'd0, 5'd3, 1), EIdle);
        push(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EIdle);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); #3;
            checks++;
            if (obs !== e || obs4 !== e) begin
                errors++;
                $display("FAIL reset c%0d outs got %b/%b want %b", cyc, obs, obs4, e);
            end
            checks++;
            if (stall_cnt !== cnt_exp || stall_cnt4 !== cnt4_exp) begin
                errors++;
                $display("FAIL reset c%0d cnt got %0d/%0d want %0d/%0d",
                         cyc, stall_cnt, stall_cnt4, cnt_exp, cnt4_exp);
            end
            model_cnt(s, e);
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_load_use();
        stim_t s; logic [9:0] e; int cyc = 0;
        push(mk(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0), ELdUse);
        push(mk(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0), EIdle);  // r0 never hazards
        push(mk(0, 0, 0, 0, 1, 5'd7, 5'd2, 5'd7, 0), ELdUse);  // match on rt
        push(mk(0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd4, 0), EIdle);   // no match
        push(mk(0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, 0), EIdle);   // not a load
        push(mk(0, 0, 0, 0, 1, 5'd31, 5'd31, 5'd0, 0), ELdUse);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); #3;
            checks++;
            if (obs !== e || obs4 !== e) begin
                errors++;
                $display("FAIL load_use c%0d outs got %b/%b want %b", cyc, obs, obs4, e);
            end
            checks++;
            if (stall_cnt !== cnt_exp || stall_cnt4 !== cnt4_exp) begin
                errors++;
                $display("FAIL load_use c%0d cnt got %0d/%0d want %0d/%0d",
                         cyc, stall_cnt, stall_cnt4, cnt_exp, cnt4_exp);
            end
            model_cnt(s, e);
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_clean_miss();
        stim_t s; logic [9:0] e; int cyc = 0;
        push(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EIdle);
        push(mk(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EMiss);
        push(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EAlloc);
        push(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EAlloc);
        push(mk(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0), EAlloc);
        push(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), ERefill);
        push(mk(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0), EIdle);   // ack ignored in idle
        push(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EIdle);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); #3;
            checks++;
            if (obs !== e || obs4 !== e) begin
                errors++;
                $display("FAIL clean_miss c%0d outs got %b/%b want %b", cyc, obs, obs4, e);
            end
            checks++;
            if (stall_cnt !== cnt_exp || stall_cnt4 !== cnt4_exp) begin
                errors++;
                $display("FAIL clean_miss c%0d cnt got %0d/%0d want %0d/%0d",
                         cyc, stall_cnt, stall_cnt4, cnt_exp, cnt4_exp);
            end
            model_cnt(s, e);
            @(posedge clk); #1; cyc++;
        end
        #3;
        checks++;
        if (stall_cnt !== 32'd5) begin
            errors++;
            $display("FAIL clean_miss total stall_cnt got %0d want 5", stall_cnt);
        end
        @(posedge clk); #1;
        model_cnt(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EIdle);
    endtask

    task automatic test_dirty_miss();
        stim_t s; logic [9:0] e; int cyc = 0;
        push(mk(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0), EMiss);
        push(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EWb);
        push(mk(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0), EWb);
        push(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EAlloc);
        push(mk(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0), EAlloc);
        push(mk(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0), ERefill); // ack ignored in refill
        push(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EIdle);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); #3;
            checks++;
            if (obs !== e || obs4 !== e) begin
                errors++;
                $display("FAIL dirty_miss c%0d outs got %b/%b want %b", cyc, obs, obs4, e);
            end
            checks++;
            if (stall_cnt !== cnt_exp || stall_cnt4 !== cnt4_exp) begin
                errors++;
                $display("FAIL dirty_miss c%0d cnt got %0d/%0d want %0d/%0d",
                         cyc, stall_cnt, stall_cnt4, cnt_exp, cnt4_exp);
            end
            model_cnt(s, e);
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_priority();
        stim_t s; logic [9:0] e; int cyc = 0;
        push(mk(0, 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1), EMiss);
        push(mk(0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1), EAlloc);
        push(mk(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1), ERefill);
        push(mk(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1), ELdUse);
        push(mk(0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd0, 1), EBranch);
        push(mk(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1), EBranch);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); #3;
            checks++;
            if (obs !== e || obs4 !== e) begin
                errors++;
                $display("FAIL priority c%0d outs got %b/%b want %b", cyc, obs, obs4, e);
            end
            checks++;
            if (stall_cnt !== cnt_exp || stall_cnt4 !== cnt4_exp) begin
                errors++;
                $display("FAIL priority c%0d cnt got %0d/%0d want %0d/%0d",
                         cyc, stall_cnt, stall_cnt4, cnt_exp, cnt4_exp);
            end
            model_cnt(s, e);
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset_mid();
        stim_t s; logic [9:0] e; int cyc = 0;
        push(mk(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EMiss);
        push(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EAlloc);
        push(mk(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0), EIdle);   // reset in ALLOC_REQ
        push(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EIdle);   // no refill pulse
        push(mk(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0), EIdle);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); #3;
            checks++;
            if (obs !== e || obs4 !== e) begin
                errors++;
                $display("FAIL reset_mid c%0d outs got %b/%b want %b", cyc, obs, obs4, e);
            end
            checks++;
            if (stall_cnt !== cnt_exp || stall_cnt4 !== cnt4_exp) begin
                errors++;
                $display("FAIL reset_mid c%0d cnt got %0d/%0d want %0d/%0d",
                         cyc, stall_cnt, stall_cnt4, cnt_exp, cnt4_exp);
            end
            model_cnt(s, e);
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_saturation();
        stim_t s; logic [9:0] e; int cyc = 0;
        push(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), EIdle);
        for (int i = 0; i < 20; i++) begin
            push(mk(0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0), ELdUse);
        end
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); #3;
            checks++;
            if (obs !== e || obs4 !== e) begin
                errors++;
                $display("FAIL saturation c%0d outs got %b/%b want %b", cyc, obs, obs4, e);
            end
            checks++;
            if (stall_cnt !== cnt_exp || stall_cnt4 !== cnt4_exp) begin
                errors++;
                $display("FAIL saturation c%0d cnt got %0d/%0d want %0d/%0d",
                         cyc, stall_cnt, stall_cnt4, cnt_exp, cnt4_exp);
            end
            model_cnt(s, e);
            @(posedge clk); #1; cyc++;
        end
        apply(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0));
        #3;
        checks++;
        if (stall_cnt4 !== 4'd15 || stall_cnt !== 32'd20) begin
            errors++;
            $display("FAIL saturation final cnt got %0d/%0d want 20/15", stall_cnt, stall_cnt4);
        end
    endtask

    initial begin
        apply(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0));
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_clean_miss();
        test_dirty_miss();
        test_priority();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
